// File: rtl/dmem_bus_if_pkg.sv
// Shared definitions for the data-memory bus interface: access size codes,
// controller state encoding and the error code reported for bus faults.
package dmem_bus_if_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Controller states (2-bit encoding)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Exception code the pipeline raises when rsp_err is returned
    localparam logic [3:0] EXCP_BUS = 4'd5;

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SIZE_B:  m = 3'b000;
            SIZE_H:  m = 3'b001;
            SIZE_W:  m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_bus_if_bus_timeout_ctr.sv
// Bus response timeout counter. Cleared while not waiting, counts wait
// cycles, saturates at all-ones. o_expired flags the wait cycle on which the
// count of elapsed wait cycles reaches i_limit; a limit of 0 never expires.
module bus_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    // Count wait cycles; hold at max rather than wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    // r_cnt holds cycles already spent, so this cycle is number r_cnt+1
    assign o_expired = i_enable && (i_limit != '0) && (r_cnt >= (i_limit - W'(1)));

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: one outstanding load/store, valid/ready on both
// the pipeline side and the bus side, timeout converts a silent bus into an
// error response. Optional macro DMEM_MISALIGN_CHK_EN rejects misaligned
// requests locally (error response, no bus traffic).
module dmem_bus_if
    import dmem_bus_if_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_we,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_rsp_valid,
    input  logic [DATA_W-1:0]   bus_rsp_data,
    input  logic                bus_rsp_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bus_req_valid;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_accept;
    logic              w_misalign;
    logic              w_expired;
    logic              w_wait;
    logic              w_wait_done;
    logic [3:0]        w_unused_bits;

    assign req_ready   = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
    assign w_accept    = req_valid && req_ready;
    assign w_wait      = (r_state == ST_WAIT);
    // A real bus response in the same cycle as expiry takes priority
    assign w_wait_done = w_wait && (bus_rsp_valid || w_expired);

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_misalign = |(req_addr[2:0] & size_mask(req_size));
`else
    assign w_misalign = 1'b0;
`endif
    // Size and byte offset only matter to the optional alignment check
    assign w_unused_bits = {req_addr[2:0], ^req_size};

    bus_timeout_ctr #(.W(CW)) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (!w_wait),
        .i_enable (w_wait),
        .i_limit  (CW'(TIMEOUT_CYCLES)),
        .o_expired(w_expired)
    );

    // Transaction sequencing; a new accept in RESP chains straight into REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= w_misalign ? ST_RESP : ST_REQ;
                ST_REQ:  if (bus_req_ready) r_state <= ST_WAIT;
                ST_WAIT: if (w_wait_done) r_state <= ST_RESP;
                default: if (rsp_ready)
                             r_state <= !w_accept ? ST_IDLE : (w_misalign ? ST_RESP : ST_REQ);
            endcase
        end
    end

    // Latch the request on accept; bus fields are then stable until the bus takes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_wstrb <= req_we ? req_wstrb : '0;
        end
    end

    // Bus request: raised the cycle after accept, dropped on bus handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bus_req_valid <= 1'b0;
        else if (w_accept && !w_misalign)
            r_bus_req_valid <= 1'b1;
        else if ((r_state == ST_REQ) && bus_req_ready)
            r_bus_req_valid <= 1'b0;
    end

    // Response capture; data is zeroed for stores and any error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_wait_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus_rsp_valid ? bus_rsp_err : 1'b1;
            r_rsp_data  <= (bus_rsp_valid && !bus_rsp_err && !r_we) ? bus_rsp_data : '0;
        end else if (w_accept && w_misalign) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_rsp_err;
    assign rsp_rdata     = r_rsp_data;
    assign bus_req_valid = r_bus_req_valid;
    assign bus_addr      = r_addr;
    assign bus_we        = r_we;
    assign bus_wdata     = r_wdata;
    assign bus_wstrb     = r_wstrb;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_dmem_bus_if;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata, rsp_rdata, bus_addr, bus_wdata, bus_rsp_data;
    logic [7:0]  req_wstrb, bus_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid, bus_rsp_err;

    dmem_bus_if #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // environment knobs
    int          p_brdy = 100, p_rrdy = 100, p_err = 0, p_noise = 0, fix_dly = 0;
    bit          fix_data = 1'b1;
    logic [63:0] fdata = 64'h0;
    int          n_bus_hs = 0;

    // bus slave + response consumer
    initial begin
        bit hs, act;
        int cnt;
        act = 0; cnt = 0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = 0; bus_rsp_err = 0; rsp_ready = 0;
        forever begin
            @(negedge clk);
            hs = bus_req_valid && bus_req_ready;
            @(posedge clk); #1;
            if (!rst_n) act = 0;
            else if (hs) begin
                act = 1; n_bus_hs++;
                cnt = (fix_dly >= 0) ? fix_dly : int'($urandom_range(5));
            end
            bus_rsp_valid = 0; bus_rsp_err = 0; bus_rsp_data = {$urandom, $urandom};
            if (act && rst_n) begin
                if (cnt == 0) begin
                    act = 0; bus_rsp_valid = 1;
                    bus_rsp_err = (int'($urandom_range(99)) < p_err);
                    if (fix_data) bus_rsp_data = fdata;
                end else cnt--;
            end else bus_rsp_valid = (int'($urandom_range(99)) < p_noise);
            bus_req_ready = (int'($urandom_range(99)) < p_brdy);
            rsp_ready     = (int'($urandom_range(99)) < p_rrdy);
        end
    end

    // transaction-level reference model and per-cycle compare
    bit          m_busy, m_hs, m_res, m_we, m_err, e_bv, e_rv, e_rr;
    int          m_wc;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_strb;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_hs = 0; m_res = 0;
        end else begin
            e_bv = m_busy && !m_hs && !m_res;
            e_rv = m_busy && m_res;
            e_rr = !m_busy || (m_res && rsp_ready);
            chk("req_ready", req_ready, e_rr);
            chk("bus_req_valid", bus_req_valid, e_bv);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_bv) begin
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_we", bus_we, m_we);
                chk("bus_wstrb", bus_wstrb, m_strb);
                if (m_we) chk("bus_wdata", bus_wdata, m_wdata);
            end
            if (e_rv) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", rsp_err, m_err);
            end
            if (m_busy && m_hs && !m_res) begin
                if (bus_rsp_valid) begin
                    m_res = 1; m_err = bus_rsp_err;
                    m_rdata = (m_we || bus_rsp_err) ? 64'h0 : bus_rsp_data;
                end else if (T != 0 && m_wc == T - 1) begin
                    m_res = 1; m_err = 1; m_rdata = 0;
                end else m_wc++;
            end else if (e_bv && bus_req_ready) begin
                m_hs = 1; m_wc = 0;
            end else if (e_rv && rsp_ready) m_busy = 0;
            if (req_valid && e_rr) begin
                m_busy = 1; m_hs = 0; m_res = 0; m_we = req_we;
                m_addr = req_addr - (req_addr % 8);
                m_wdata = req_wdata; m_strb = req_we ? req_wstrb : 8'h0;
`ifdef DMEM_MISALIGN_CHK_EN
                if ((int'(req_addr[2:0]) % (1 << req_size)) != 0) begin
                    m_res = 1; m_err = 1; m_rdata = 0;
                end
`endif
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_bus_req_valid"}, bus_req_valid, 0);
        chk({tag, "_bus_we"}, bus_we, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wstrb"}, bus_wstrb, 0);
    endtask

    // present a request until accepted; returns at posedge+1 after the accept edge
    task automatic do_req(input bit we, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] wd, input logic [7:0] st, input bit keep,
                          output time t_acc);
        bit acc;
        acc = 0; t_acc = 0;
        req_valid = 1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd; req_wstrb = st;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk); acc = req_ready; t_acc = $time;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        if (!keep) req_valid = 0;
    endtask

    // cycles from the accept cycle to the first rsp_valid cycle
    task automatic wait_rsp(output int lat, output logic [63:0] d, output logic e);
        lat = -1; d = 'x; e = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = i; d = rsp_rdata; e = rsp_err; break; end
        end
        if (lat < 0) chk("rsp_wait_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        time         ta, tb;
        int          lat, h0;
        logic [63:0] d, a;
        logic        e;
        logic [1:0]  sz;
        req_valid = 0; req_we = 0; req_size = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        #1 chk_reset("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk); #1;

        // 1: zero-wait doubleword load
        fdata = 64'h1122334455667788;
        do_req(0, 2'd3, 64'h80000008, 64'h0, 8'hFF, 0, ta);
        #1 chk("t1_bus_addr", bus_addr, 64'h80000008);
        chk("t1_bus_wstrb", bus_wstrb, 8'h00);
        wait_rsp(lat, d, e);
        chk("t1_latency", lat, 3);
        chk("t1_rdata", d, 64'h1122334455667788);
        chk("t1_err", e, 0);

        // 2: halfword store into lanes 2..3
        do_req(1, 2'd1, 64'h80000002, 64'h00000000BEEF0000, 8'h0C, 0, ta);
        #1 chk("t2_bus_addr", bus_addr, 64'h80000000);
        chk("t2_bus_we", bus_we, 1);
        chk("t2_bus_wstrb", bus_wstrb, 8'h0C);
        chk("t2_bus_wdata", bus_wdata, 64'h00000000BEEF0000);
        wait_rsp(lat, d, e);
        chk("t2_rdata", d, 64'h0);

        // 3: bus back-pressure then consumer back-pressure
        fdata = 64'hCAFEF00D12345678; p_brdy = 0; p_rrdy = 0; h0 = n_bus_hs;
        do_req(0, 2'd3, 64'h80000010, 64'h0, 8'h00, 0, ta);
        repeat (5) @(posedge clk);
        p_brdy = 100;
        wait_rsp(lat, d, e);
        repeat (2) @(posedge clk);
        #1 chk("t3_rsp_held", rsp_valid, 1);
        chk("t3_rdata_held", rsp_rdata, 64'hCAFEF00D12345678);
        p_rrdy = 100;
        repeat (3) @(posedge clk); #1;
        chk("t3_one_bus_req", n_bus_hs - h0, 1);

        // 4: timeout, late response ignored, next load fine
        fix_dly = 6;
        do_req(0, 2'd3, 64'h80000018, 64'h0, 8'h00, 0, ta);
        wait_rsp(lat, d, e);
        chk("t4_tmo_latency", lat, 2 + T);
        chk("t4_tmo_err", e, 1);
        chk("t4_tmo_rdata", d, 0);
        repeat (6) @(posedge clk); #1;
        fix_dly = 0; fdata = 64'h0123456789ABCDEF;
        do_req(0, 2'd3, 64'h80000020, 64'h0, 8'h00, 0, ta);
        wait_rsp(lat, d, e);
        chk("t4_next_err", e, 0);
        chk("t4_next_rdata", d, 64'h0123456789ABCDEF);

        // 5: back-to-back loads, second accepted in first's RESP cycle
        fix_data = 0;
        do_req(0, 2'd3, 64'h80000028, 64'h0, 8'h00, 1, ta);
        do_req(0, 2'd2, 64'h80000034, 64'h0, 8'h00, 0, tb);
        chk("t5_b2b_gap", (tb - ta) / 10, 3);
        wait_rsp(lat, d, e);
        chk("t5_second_latency", lat, 3);

        // 6: async reset in WAIT abandons the transaction
        fix_dly = 20;
        do_req(0, 2'd3, 64'h80000040, 64'h0, 8'h00, 0, ta);
        repeat (2) @(posedge clk);
        #3 rst_n = 0;
        #1 chk_reset("mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1; fix_dly = 0;
        repeat (25) @(posedge clk); #1;

`ifdef DMEM_MISALIGN_CHK_EN
        h0 = n_bus_hs;
        do_req(0, 2'd2, 64'h80000002, 64'h0, 8'h00, 0, ta);
        wait_rsp(lat, d, e);
        chk("t7_mis_latency", lat, 1);
        chk("t7_mis_err", e, 1);
        chk("t7_mis_no_bus", n_bus_hs - h0, 0);
`endif

        // randomized traffic
        p_brdy = 70; p_rrdy = 70; p_err = 15; p_noise = 10; fix_dly = -1;
        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(3));
            a = {32'h8000_0000, $urandom};
            if ($urandom_range(9) != 0) a = a - (a % (64'd1 << sz));
            do_req(1'($urandom_range(1)), sz, a, {$urandom, $urandom},
                   8'($urandom), 1'($urandom_range(1)), ta);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
        req_valid = 0; p_rrdy = 100;
        repeat (30) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
        $fatal(1);
    end

endmodule
